// File: rtl/enum_mon_pkg.sv
// rtl/enum_mon_pkg.sv - shared enums and level ordering helper for the level monitor
package enum_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;
  typedef enum logic [1:0] {OFF, LOW, MED, HIGH} level_t;
  typedef enum int {ERR = -1, OK = 0, WARN = 1} status_t;

  // Encoding order matches severity, so the numeric compare is the level order.
  function automatic level_t level_max(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enum_high_run_detector.sv
// rtl/enum_high_run_detector.sv - saturating consecutive-HIGH run counter with sticky error
module enum_high_run_detector #(
  parameter int HIGH_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic is_high_i,
  input  logic clear_i,
  output logic hit_o,
  output logic err_sticky_o
);

  localparam int RUN_W = $clog2(HIGH_LIMIT + 1);
  localparam logic [RUN_W-1:0] LIMIT     = RUN_W'(HIGH_LIMIT);
  localparam logic [RUN_W-1:0] LIMIT_M1  = RUN_W'(HIGH_LIMIT - 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;

  // hit_o flags the sample that makes the run reach the limit, so callers can
  // fold it into a verdict on the same edge the sticky flag is set.
  assign hit_o        = sample_i && is_high_i && !clear_i && (run_q >= LIMIT_M1);
  assign err_sticky_o = err_q;

  always_comb begin
    run_d = run_q;
    err_d = err_q;
    if (clear_i) begin
      run_d = '0;
      err_d = 1'b0;
    end else if (sample_i) begin
      if (is_high_i) run_d = (run_q == LIMIT) ? LIMIT : run_q + RUN_W'(1);
      else           run_d = '0;
      err_d = err_q | hit_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
      err_q <= 1'b0;
    end else begin
      run_q <= run_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/enum_level_monitor.sv
// rtl/enum_level_monitor.sv - windowed level monitor emitting ERR/OK/WARN verdicts
// Optional early abort on HIGH-run error: ENUM_LEVEL_MONITOR_ABORT_EN.
module enum_level_monitor
  import enum_mon_pkg::*;
#(
  parameter  int WINDOW     = 8,
  parameter  int HIGH_LIMIT = 3,
  localparam int CNT_W      = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_status,
  output logic [1:0]       out_peak,
  output logic [CNT_W-1:0] out_samples,
  output logic [1:0]       state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  level_t           peak_q, peak_d;
  logic             out_valid_q, out_valid_d;
  status_t          out_status_q, out_status_d;
  level_t           out_peak_q, out_peak_d;
  logic [CNT_W-1:0] out_samples_q, out_samples_d;

  logic             accept, det_sample, det_clear, det_hit, err_sticky;
  level_t           lvl, peak_upd;
  logic [CNT_W-1:0] count_inc;
  logic             finish;

  assign in_ready  = (state_q != DONE);
  assign accept    = in_valid && in_ready;
  assign lvl       = level_t'(in_level);
  assign count_inc = count_q + CNT_W'(1);
  assign peak_upd  = level_max(peak_q, lvl);

  enum_high_run_detector #(.HIGH_LIMIT(HIGH_LIMIT)) u_high_run (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (det_sample),
    .is_high_i    (lvl == HIGH),
    .clear_i      (det_clear),
    .hit_o        (det_hit),
    .err_sticky_o (err_sticky)
  );

`ifdef ENUM_LEVEL_MONITOR_ABORT_EN
  assign finish = (count_inc == CNT_W'(WINDOW)) || det_hit;
`else
  assign finish = (count_inc == CNT_W'(WINDOW));
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    peak_d        = peak_q;
    out_valid_d   = out_valid_q;
    out_status_d  = out_status_q;
    out_peak_d    = out_peak_q;
    out_samples_d = out_samples_q;
    det_sample    = 1'b0;
    det_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && lvl != OFF) begin
          state_d    = RUNNING;
          count_d    = CNT_W'(1);
          peak_d     = lvl;
          det_sample = 1'b1;
        end
      end
      RUNNING: begin
        if (accept) begin
          count_d    = count_inc;
          peak_d     = peak_upd;
          det_sample = 1'b1;
          // Verdict is latched on the accepting edge; the run detector's hit
          // covers the limit-reaching sample before err_sticky is visible.
          if (finish) begin
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_peak_d    = peak_upd;
            out_samples_d = count_inc;
            if (err_sticky || det_hit) out_status_d = ERR;
            else if (peak_upd >= MED)  out_status_d = WARN;
            else                       out_status_d = OK;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          count_d     = '0;
          peak_d      = OFF;
          det_clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      peak_q        <= OFF;
      out_valid_q   <= 1'b0;
      out_status_q  <= OK;
      out_peak_q    <= OFF;
      out_samples_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      peak_q        <= peak_d;
      out_valid_q   <= out_valid_d;
      out_status_q  <= out_status_d;
      out_peak_q    <= out_peak_d;
      out_samples_q <= out_samples_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_status  = out_status_q;
  assign out_peak    = out_peak_q;
  assign out_samples = out_samples_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_enum_level_monitor.sv
// tb/tb_enum_level_monitor.sv - directed self-checking bench for enum_level_monitor
module tb_enum_level_monitor;

  localparam logic [1:0] L_OFF = 2'd0, L_LOW = 2'd1, L_MED = 2'd2, L_HIGH = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_level = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_status;
  logic [1:0]  out_peak;
  logic [3:0]  out_samples;
  logic [1:0]  state_o;

  int checks = 0;
  int failures = 0;

  enum_level_monitor #(.WINDOW(8), .HIGH_LIMIT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_level    (in_level),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_status  (out_status),
    .out_peak    (out_peak),
    .out_samples (out_samples),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] lvl);
    in_valid = 1'b1;
    in_level = lvl;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_state", 32'(state_o), 32'(S_IDLE));
  endtask

  // seq[0] is the first sample sent
  task automatic run_window(input string tag, input logic [0:7][1:0] seq,
                            input int exp_status, input logic [1:0] exp_peak);
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      if (i == 6) chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    chk({tag, "_valid"},   32'(out_valid),   32'd1);
    chk({tag, "_state"},   32'(state_o),     32'(S_DONE));
    chk({tag, "_status"},  out_status,       32'(exp_status));
    chk({tag, "_peak"},    32'(out_peak),    32'(exp_peak));
    chk({tag, "_samples"}, 32'(out_samples), 32'd8);
    chk({tag, "_inready"}, 32'(in_ready),    32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #20;
    chk("rst_state",   32'(state_o),     32'(S_IDLE));
    chk("rst_valid",   32'(out_valid),   32'd0);
    chk("rst_status",  out_status,       32'd0);
    chk("rst_peak",    32'(out_peak),    32'd0);
    chk("rst_samples", 32'(out_samples), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_inready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 3; i++) send(L_OFF);
    chk("off_ignored", 32'(state_o), 32'(S_IDLE));
    run_window("low8", {8{L_LOW}}, 0, L_LOW);
    drain();

    run_window("warn", {L_LOW, L_MED, L_LOW, L_LOW, L_LOW, L_LOW, L_LOW, L_LOW}, 1, L_MED);
    drain();

`ifdef ENUM_LEVEL_MONITOR_ABORT_EN
    send(L_LOW); send(L_HIGH); send(L_HIGH); send(L_HIGH);
    chk("abort_valid",   32'(out_valid),   32'd1);
    chk("abort_state",   32'(state_o),     32'(S_DONE));
    chk("abort_status",  out_status,       32'hffff_ffff);
    chk("abort_samples", 32'(out_samples), 32'd4);
    drain();
`else
    run_window("err", {L_LOW, L_HIGH, L_HIGH, L_HIGH, L_LOW, L_LOW, L_LOW, L_LOW}, -1, L_HIGH);
    drain();
`endif

    run_window("nonconsec", {L_HIGH, L_HIGH, L_LOW, L_HIGH, L_HIGH, L_LOW, L_LOW, L_LOW}, 1, L_HIGH);
    drain();

    // verdict held under backpressure while a sample is offered
    run_window("hold", {L_MED, L_LOW, L_LOW, L_LOW, L_LOW, L_LOW, L_LOW, L_LOW}, 1, L_MED);
    in_valid = 1'b1;
    in_level = L_HIGH;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_inready", 32'(in_ready),    32'd0);
      chk("hold_valid",   32'(out_valid),   32'd1);
      chk("hold_status",  out_status,       32'd1);
      chk("hold_peak",    32'(out_peak),    32'(L_MED));
      chk("hold_samples", 32'(out_samples), 32'd8);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_state", 32'(state_o),   32'(S_IDLE));
    chk("release_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("next_accept_state", 32'(state_o), 32'(S_RUN));

    // four more samples: count reaches 5, then reset mid-window
    for (int i = 0; i < 4; i++) send(L_LOW);
    chk("pre_rst_state", 32'(state_o),   32'(S_RUN));
    chk("pre_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state_o),   32'(S_IDLE));
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_status", out_status,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // after reset, a fresh window counts from scratch (no carry-over of 5)
    run_window("post_rst", {8{L_LOW}}, 0, L_LOW);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
